// File: rtl/aud_key_pkg.sv
// Shared types and default 12 MHz timings for the push-button front end.
package aud_key_pkg;

    typedef enum logic [1:0] {S_UP, S_DOWN, S_LONG} key_state_e;

    localparam int unsigned DEB_CYCLES_DEF    = 120_000;
    localparam int unsigned LONG_CYCLES_DEF   = 9_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 2_400_000;

endpackage

// File: rtl/key_sync_filter.sv
// Two-flop synchroniser plus debounce counter for one active-low key pin;
// emits the debounced raw level and single-cycle strobes when it changes.
module key_sync_filter
    import aud_key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_stable,
    output logic o_fall,
    output logic o_rise
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= 1'b1;
            sync_q    <= 1'b1;
            stable_q  <= 1'b1;
            fall_q    <= 1'b0;
            rise_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= i_in;
            sync_q    <= sync1_q;
            stable_q  <= stable_d;
            fall_q    <= fall_d;
            rise_q    <= rise_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Any cycle where sync agrees with stable restarts the qualification window.
    always_comb begin
        stable_d  = stable_q;
        fall_d    = 1'b0;
        rise_d    = 1'b0;
        deb_cnt_d = '0;
        if (sync_q != stable_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                stable_d = sync_q;
                fall_d   = ~sync_q;
                rise_d   = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign o_stable = stable_q;
    assign o_fall   = fall_q;
    assign o_rise   = rise_q;

endmodule

// File: rtl/key_press_decoder.sv
// Per-key front end: debounced level plus press/release/short/long pulses.
// Define KEY_REPEAT_EN to add the auto-repeat pulse train on o_rep.
module key_press_decoder
    import aud_key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_neg,
    output logic o_pos,
    output logic o_short,
    output logic o_long,
    output logic o_rep
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    if (DEB_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_timing
        $error("key_press_decoder: timing parameters out of range");
    end

    logic stable;
    logic fall;
    logic rise;

    key_sync_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_filter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_in     (i_in),
        .o_stable (stable),
        .o_fall   (fall),
        .o_rise   (rise)
    );

    key_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              level_q, level_d;
    logic              neg_q, neg_d;
    logic              pos_q, pos_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    assign o_rep = rep_q;
`else
    assign o_rep = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_UP;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            neg_q      <= 1'b0;
            pos_q      <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            neg_q      <= neg_d;
            pos_q      <= pos_d;
            short_q    <= short_d;
            long_q     <= long_d;
        end
    end

    // Release is tested before the long threshold so it wins a same-cycle tie.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = ~stable;
        neg_d      = 1'b0;
        pos_d      = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_d      = 1'b0;
`endif
        unique case (state_q)
            S_UP: begin
                if (fall) begin
                    state_d    = S_DOWN;
                    hold_cnt_d = '0;
                    neg_d      = 1'b1;
                end
            end
            S_DOWN: begin
                if (rise) begin
                    state_d = S_UP;
                    pos_d   = 1'b1;
                    short_d = 1'b1;
                end else if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_LONG: begin
                if (rise) begin
                    state_d = S_UP;
                    pos_d   = 1'b1;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                        rep_cnt_d = '0;
                        rep_d     = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_UP;
        endcase
    end

    assign o_level = level_q;
    assign o_neg   = neg_q;
    assign o_pos   = pos_q;
    assign o_short = short_q;
    assign o_long  = long_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder with DEB=4, LONG=20, REPEAT=5.
module tb_key_press_decoder;

`ifdef KEY_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic clk;
    logic i_rst_n;
    logic i_in;
    logic o_level, o_neg, o_pos, o_short, o_long, o_rep;

    key_press_decoder #(
        .DEB_CYCLES    (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_in    (i_in),
        .o_level (o_level),
        .o_neg   (o_neg),
        .o_pos   (o_pos),
        .o_short (o_short),
        .o_long  (o_long),
        .o_rep   (o_rep)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int neg_n, pos_n, short_n, long_n, rep_n, lvl_n;
    int neg_at, pos_at, short_at, long_at, rep_first, rep_last;
    int n_checks = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        if (o_level) lvl_n++;
        if (o_neg)   begin neg_n++;   neg_at   = cyc; end
        if (o_pos)   begin pos_n++;   pos_at   = cyc; end
        if (o_short) begin short_n++; short_at = cyc; end
        if (o_long)  begin long_n++;  long_at  = cyc; end
        if (o_rep) begin
            if (rep_n == 0) rep_first = cyc;
            rep_last = cyc;
            rep_n++;
        end
    end

    task automatic clr();
        neg_n = 0; pos_n = 0; short_n = 0; long_n = 0; rep_n = 0; lvl_n = 0;
        neg_at = -1; pos_at = -1; short_at = -1; long_at = -1;
        rep_first = -1; rep_last = -1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    int t;

    initial begin
        clr();
        i_rst_n = 1'b0;
        i_in    = 1'b0;
        wait_cyc(3);
        chk("reset_outputs", int'({o_level, o_neg, o_pos, o_short, o_long, o_rep}), 0);

        // Reset released with key already held
        clr();
        i_rst_n = 1'b1;
        t = cyc;
        wait_cyc(12);
        chk("rst_held_neg_count", neg_n, 1);
        chk("rst_held_neg_cycle", neg_at, t + 7);
        chk("rst_held_level", int'(o_level), 1);
        i_in = 1'b1;
        wait_cyc(12);
        chk("rst_held_release_pos", pos_n, 1);

        // Glitch shorter than the debounce window
        clr();
        i_in = 1'b0;
        wait_cyc(3);
        i_in = 1'b1;
        wait_cyc(15);
        chk("glitch_pulses", neg_n + pos_n + short_n + long_n + rep_n, 0);
        chk("glitch_level", lvl_n, 0);

        // Short press
        clr();
        i_in = 1'b0;
        t = cyc;
        wait_cyc(10);
        i_in = 1'b1;
        wait_cyc(12);
        chk("short_neg_cycle", neg_at, t + 7);
        chk("short_pos_cycle", pos_at, t + 17);
        chk("short_short_cycle", short_at, t + 17);
        chk("short_counts", neg_n * 100 + pos_n * 10 + short_n, 111);
        chk("short_no_long", long_n, 0);
        chk("short_level_high_cycles", lvl_n, 10);

        // Long press
        clr();
        i_in = 1'b0;
        t = cyc;
        wait_cyc(40);
        i_in = 1'b1;
        wait_cyc(12);
        chk("long_neg_cycle", neg_at, t + 7);
        chk("long_long_count", long_n, 1);
        chk("long_long_cycle", long_at, t + 27);
        chk("long_pos_cycle", pos_at, t + 47);
        chk("long_no_short", short_n, 0);
        chk("long_rep_count", rep_n, REP_ON ? 3 : 0);

        // Hold 40 cycles past o_long
        clr();
        i_in = 1'b0;
        t = cyc;
        wait_cyc(61);
        i_in = 1'b1;
        wait_cyc(12);
        chk("rep_long_cycle", long_at, t + 27);
        chk("rep_count", rep_n, REP_ON ? 8 : 0);
        chk("rep_first_cycle", rep_first, REP_ON ? t + 32 : -1);
        chk("rep_last_cycle", rep_last, REP_ON ? t + 67 : -1);
        chk("rep_pos_cycle", pos_at, t + 68);
        chk("rep_no_short", short_n, 0);

        // Bounce: 2-cycle toggles, then settle low
        clr();
        for (int i = 0; i < 10; i++) begin
            i_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_cyc(2);
        end
        i_in = 1'b0;
        t = cyc;
        wait_cyc(12);
        chk("bounce_neg_count", neg_n, 1);
        chk("bounce_neg_cycle", neg_at, t + 7);
        chk("bounce_no_pos", pos_n, 0);

        // Asynchronous reset while the key is down
        chk("midrst_level_before", int'(o_level), 1);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_level_async", int'(o_level), 0);
        @(posedge clk);
        #1;
        clr();
        i_rst_n = 1'b1;
        t = cyc;
        wait_cyc(12);
        chk("midrst_reaccept_count", neg_n, 1);
        chk("midrst_reaccept_cycle", neg_at, t + 7);
        i_in = 1'b1;
        wait_cyc(12);
        chk("midrst_release_short", short_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
